if_stage: RTL and testbench
===========================

IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, the PC value loaded on reset.
REQ-002 The block SHALL have parameter IMEM_BYTES, default 80, the instruction memory size in bytes.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-004 The block SHALL have port rst, input, 1, the synchronous active-high reset.
REQ-005 The block SHALL have port stall, input, 1, which holds the PC and IF/ID register.
REQ-006 The block SHALL have port flush, input, 1, which invalidates the IF/ID register.
REQ-007 The block SHALL have port redirect, input, 1, the branch/jump taken signal from downstream.
REQ-008 The block SHALL have port redirect_pc, input, 32, the target PC when redirect=1.
REQ-009 The block SHALL have port imem_addr, output, 32, the byte address to the instruction memory.
REQ-010 The block SHALL have port imem_data, input, 32, the little-endian instruction word from memory, combinational from imem_addr.
REQ-011 The block SHALL have port ifid_pc, output, 32, the PC of the latched instruction.
REQ-012 The block SHALL have port ifid_ins, output, 32, the latched instruction.
REQ-013 The block SHALL have port ifid_valid, output, 1, which is high when ifid_ins is a real-path instruction.
REQ-014 The block SHALL have port fetch_fault, output, 1, a sticky misaligned/out-of-range fetch flag.
REQ-015 The block SHALL have port fetch_count, output, 32, the count of valid instructions latched.

Function
REQ-016 The block SHALL drive imem_addr combinationally equal to the internal pc register, with no added latency.
REQ-017 Next-pc priority SHALL be: rst, then redirect, then stall, then pc+4.
REQ-018 Redirect SHALL win over stall: pc <= {redirect_pc[31:2],2'b00}.
REQ-019 pc+4 SHALL wrap modulo 2^32 with no fault raised on wrap.
REQ-020 IF/ID capture SHALL have 1-cycle latency: on an edge with stall=0, ifid_pc <= pc and ifid_ins <= imem_data (or NOP per REQ-023).
REQ-021 ifid_valid SHALL update as follows: flush=1 or redirect=1 gives 0 (wrong-path squash, stall ignored); else stall=1 holds; else 1.
REQ-022 While stall=1 and flush=0 and redirect=0, pc, ifid_pc, ifid_ins, ifid_valid and fetch_count SHALL all hold.
REQ-023 An out-of-range fetch (pc > IMEM_BYTES-4) SHALL latch ifid_ins <= 32'h0000_0013 (NOP), keep ifid_valid per REQ-021, and set fetch_fault.
REQ-024 A redirect with redirect_pc[1:0] != 0 SHALL set fetch_fault, and the pc SHALL take the aligned value.
REQ-025 fetch_fault SHALL be sticky and cleared only by rst.
REQ-026 fetch_count SHALL increment by 1 on every edge where ifid_valid is written to 1, and wrap at 2^32.
REQ-027 When flush and stall are both high, pc SHALL hold and ifid_valid SHALL go to 0.

Reset
REQ-028 On a clk edge with rst=1: pc <= RESET_PC, ifid_pc <= 0, ifid_ins <= 32'h0000_0013, ifid_valid <= 0, fetch_fault <= 0, fetch_count <= 0.
REQ-029 rst SHALL override stall, flush and redirect on the same edge.
REQ-030 Reset mid-stall or mid-redirect SHALL discard all pending state.
REQ-031 In the first cycle after reset release, imem_addr SHALL equal RESET_PC, and ifid_valid SHALL rise on the following edge.

Verification
REQ-032 Reset then free-run; memory holds 0x00500093 at 0 and 0x00400113 at 4 -> edge1: ifid_pc=0, ifid_ins=0x00500093, valid=1; edge2: ifid_pc=4, ifid_ins=0x00400113; fetch_count=2.
REQ-033 stall=1 for 3 cycles at pc=8 -> imem_addr stays 8, IF/ID and fetch_count unchanged; release -> next edge ifid_pc=8.
REQ-034 redirect=1, redirect_pc=16, with pc=12 -> next edge: pc=16, ifid_valid=0; following edge: ifid_pc=16, valid=1.
REQ-035 redirect=1 with redirect_pc=0x0000_0012 -> pc=0x10, fetch_fault=1, and fault stays 1 until rst.
REQ-036 pc reaches 80 (IMEM_BYTES=80) -> ifid_ins=0x00000013, fetch_fault=1; stall=1 and flush=1 together -> pc holds, ifid_valid=0.
REQ-037 rst asserted while stall=1 and redirect=1 -> all outputs at reset values on that edge, and imem_addr=RESET_PC.

Source files
------------

// File: rtl/if_stage.sv
// Instruction fetch stage: owns the PC, drives the instruction memory address
// and latches the fetched word into the IF/ID pipeline register.
module if_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_BYTES = 80
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  output logic [31:0] ifid_pc,
  output logic [31:0] ifid_ins,
  output logic        ifid_valid,
  output logic        fetch_fault,
  output logic [31:0] fetch_count
);

  localparam logic [31:0] NOP       = 32'h0000_0013;
  localparam logic [31:0] LAST_ADDR = 32'(IMEM_BYTES - 4);

  logic [31:0] pc;
  logic [31:0] pc_next;
  logic [31:0] ifid_pc_next;
  logic [31:0] ifid_ins_next;
  logic        ifid_valid_next;
  logic        fetch_fault_next;
  logic [31:0] fetch_count_next;
  logic        fetch_bad_c;
  logic        squash_c;

  assign imem_addr   = pc;
  assign fetch_bad_c = (pc > LAST_ADDR) || (pc[1:0] != 2'b00);
  assign squash_c    = flush || redirect;

  // Next-state logic; reset is applied in the register process.
  always_comb begin
    pc_next          = pc;
    ifid_pc_next     = ifid_pc;
    ifid_ins_next    = ifid_ins;
    ifid_valid_next  = ifid_valid;
    fetch_fault_next = fetch_fault;
    fetch_count_next = fetch_count;

    if (redirect) begin
      pc_next = {redirect_pc[31:2], 2'b00};
    end else if (!stall) begin
      pc_next = pc + 32'd4;
    end

    if (redirect && (redirect_pc[1:0] != 2'b00)) begin
      fetch_fault_next = 1'b1;
    end

    // Capture happens whenever the stage is not stalled, even on a squash.
    if (!stall) begin
      ifid_pc_next  = pc;
      ifid_ins_next = fetch_bad_c ? NOP : imem_data;
      if (fetch_bad_c) begin
        fetch_fault_next = 1'b1;
      end
    end

    if (squash_c) begin
      ifid_valid_next = 1'b0;
    end else if (!stall) begin
      ifid_valid_next  = 1'b1;
      fetch_count_next = fetch_count + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= RESET_PC;
      ifid_pc     <= 32'd0;
      ifid_ins    <= NOP;
      ifid_valid  <= 1'b0;
      fetch_fault <= 1'b0;
      fetch_count <= 32'd0;
    end else begin
      pc          <= pc_next;
      ifid_pc     <= ifid_pc_next;
      ifid_ins    <= ifid_ins_next;
      ifid_valid  <= ifid_valid_next;
      fetch_fault <= fetch_fault_next;
      fetch_count <= fetch_count_next;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed vector table followed by a randomized run,
// both feeding expected state through a scoreboard queue.
module tb_if_stage;

  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] JUNK = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        rst, stall, flush, redirect;
  logic [31:0] redirect_pc, imem_addr, imem_data;
  logic [31:0] ifid_pc, ifid_ins, fetch_count;
  logic        ifid_valid, fetch_fault;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ipc;
    logic [31:0] ins;
    logic        v;
    logic        f;
    logic [31:0] cnt;
  } exp_t;

  typedef struct {
    logic        r, s, fl, rd;
    logic [31:0] rp;
    exp_t        e;
  } vec_t;

  exp_t        sbq[$];
  vec_t        tbl[$];
  logic [31:0] mem [20];
  int          total = 0;
  int          bad   = 0;

  if_stage #(.RESET_PC(32'h0), .IMEM_BYTES(80)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem_addr(imem_addr), .imem_data(imem_data),
    .ifid_pc(ifid_pc), .ifid_ins(ifid_ins), .ifid_valid(ifid_valid),
    .fetch_fault(fetch_fault), .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rd_mem(input logic [31:0] a);
    if (a < 32'd80 && a[1:0] == 2'b00) return mem[a[6:2]];
    return JUNK;
  endfunction

  always_comb imem_data = rd_mem(imem_addr);

  function automatic exp_t ex(input logic [31:0] pc, ipc, ins, input logic v, f,
                              input logic [31:0] cnt);
    exp_t e;
    e.pc = pc; e.ipc = ipc; e.ins = ins; e.v = v; e.f = f; e.cnt = cnt;
    return e;
  endfunction

  function automatic vec_t mk(input logic r, s, fl, rd, input logic [31:0] rp,
                              input exp_t e);
    vec_t t;
    t.r = r; t.s = s; t.fl = fl; t.rd = rd; t.rp = rp; t.e = e;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, queue its expectation, compare after the edge.
  task automatic apply(input logic r, s, fl, rd, input logic [31:0] rp, input exp_t e);
    exp_t g;
    @(negedge clk);
    rst = r; stall = s; flush = fl; redirect = rd; redirect_pc = rp;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    if (sbq.size() == 0) begin
      total++; bad++;
      $display("FAIL scoreboard_empty at %0t", $time);
    end else begin
      g = sbq.pop_front();
      chk("imem_addr", imem_addr, g.pc);
      chk("ifid_pc", ifid_pc, g.ipc);
      chk("ifid_ins", ifid_ins, g.ins);
      chk("ifid_valid", 32'(ifid_valid), 32'(g.v));
      chk("fetch_fault", 32'(fetch_fault), 32'(g.f));
      chk("fetch_count", fetch_count, g.cnt);
    end
  endtask

  function automatic logic [31:0] w(input int i);
    return 32'hA000_0000 | 32'(i);
  endfunction

  exp_t m;
  logic r, s, fl, rd, oor;
  logic [31:0] rp;

  initial begin
    for (int i = 0; i < 20; i++) mem[i] = w(i);
    mem[0] = 32'h0050_0093;
    mem[1] = 32'h0040_0113;
    rst = 1'b1; stall = 1'b0; flush = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;

    //                r  s  fl rd rp            pc            ipc           ins            v  f  cnt
    tbl.push_back(mk(1, 0, 0, 0, 32'h0,  ex(32'h0,        32'h0,        NOP,           0, 0, 0)));
    tbl.push_back(mk(0, 0, 0, 0, 32'h0,  ex(32'h4,        32'h0,        32'h0050_0093, 1, 0, 1)));
    tbl.push_back(mk(0, 0, 0, 0, 32'h0,  ex(32'h8,        32'h4,        32'h0040_0113, 1, 0, 2)));
    tbl.push_back(mk(0, 1, 0, 0, 32'h0,  ex(32'h8,        32'h4,        32'h0040_0113, 1, 0, 2)));
    tbl.push_back(mk(0, 1, 0, 0, 32'h0,  ex(32'h8,        32'h4,        32'h0040_0113, 1, 0, 2)));
    tbl.push_back(mk(0, 1, 0, 0, 32'h0,  ex(32'h8,        32'h4,        32'h0040_0113, 1, 0, 2)));
    tbl.push_back(mk(0, 0, 0, 0, 32'h0,  ex(32'hC,        32'h8,        w(2),          1, 0, 3)));
    tbl.push_back(mk(0, 0, 0, 1, 32'h10, ex(32'h10,       32'hC,        w(3),          0, 0, 3)));
    tbl.push_back(mk(0, 0, 0, 0, 32'h0,  ex(32'h14,       32'h10,       w(4),          1, 0, 4)));
    tbl.push_back(mk(0, 0, 0, 1, 32'h12, ex(32'h10,       32'h14,       w(5),          0, 1, 4)));
    tbl.push_back(mk(0, 0, 0, 0, 32'h0,  ex(32'h14,       32'h10,       w(4),          1, 1, 5)));
    tbl.push_back(mk(0, 0, 0, 1, 32'h4C, ex(32'h4C,       32'h14,       w(5),          0, 1, 5)));
    tbl.push_back(mk(0, 0, 0, 0, 32'h0,  ex(32'h50,       32'h4C,       w(19),         1, 1, 6)));
    tbl.push_back(mk(0, 0, 0, 0, 32'h0,  ex(32'h54,       32'h50,       NOP,           1, 1, 7)));
    tbl.push_back(mk(0, 1, 1, 0, 32'h0,  ex(32'h54,       32'h50,       NOP,           0, 1, 7)));
    tbl.push_back(mk(0, 0, 0, 0, 32'h0,  ex(32'h58,       32'h54,       NOP,           1, 1, 8)));
    tbl.push_back(mk(1, 1, 0, 1, 32'h28, ex(32'h0,        32'h0,        NOP,           0, 0, 0)));
    tbl.push_back(mk(0, 0, 0, 0, 32'h0,  ex(32'h4,        32'h0,        32'h0050_0093, 1, 0, 1)));
    tbl.push_back(mk(0, 0, 1, 0, 32'h0,  ex(32'h8,        32'h4,        32'h0040_0113, 0, 0, 1)));
    tbl.push_back(mk(0, 0, 0, 0, 32'h0,  ex(32'hC,        32'h8,        w(2),          1, 0, 2)));
    tbl.push_back(mk(0, 1, 0, 1, 32'h8,  ex(32'h8,        32'h8,        w(2),          0, 0, 2)));
    tbl.push_back(mk(0, 0, 0, 0, 32'h0,  ex(32'hC,        32'h8,        w(2),          1, 0, 3)));
    tbl.push_back(mk(0, 0, 0, 1, 32'hFFFF_FFFC,
                                         ex(32'hFFFF_FFFC, 32'hC,       w(3),          0, 0, 3)));
    tbl.push_back(mk(0, 0, 0, 0, 32'h0,  ex(32'h0,        32'hFFFF_FFFC, NOP,          1, 1, 4)));
    tbl.push_back(mk(0, 0, 0, 0, 32'h0,  ex(32'h4,        32'h0,        32'h0050_0093, 1, 1, 5)));

    foreach (tbl[i]) apply(tbl[i].r, tbl[i].s, tbl[i].fl, tbl[i].rd, tbl[i].rp, tbl[i].e);

    // Randomized run against a behavioural model of the stage.
    m = ex(32'h0, 32'h0, NOP, 0, 0, 0);
    apply(1, 0, 0, 0, 32'h0, m);
    for (int k = 0; k < 300; k++) begin
      r  = ($urandom_range(0, 39) == 0);
      s  = ($urandom_range(0, 3) == 0);
      fl = ($urandom_range(0, 9) == 0);
      rd = ($urandom_range(0, 6) == 0);
      rp = 32'($urandom_range(0, 100));
      if (r) begin
        m = ex(32'h0, 32'h0, NOP, 0, 0, 0);
      end else begin
        if (rd && rp[1:0] != 2'b00) m.f = 1'b1;
        if (!s) begin
          oor   = (m.pc > 32'd76) || (m.pc[1:0] != 2'b00);
          m.ipc = m.pc;
          m.ins = oor ? NOP : rd_mem(m.pc);
          if (oor) m.f = 1'b1;
        end
        if (fl || rd) m.v = 1'b0;
        else if (!s) begin
          m.v   = 1'b1;
          m.cnt = m.cnt + 32'd1;
        end
        if (rd) m.pc = {rp[31:2], 2'b00};
        else if (!s) m.pc = m.pc + 32'd4;
      end
      apply(r, s, fl, rd, rp, m);
    end

    if (sbq.size() != 0) begin
      total++; bad++;
      $display("FAIL scoreboard_leftover: got %0d want 0", sbq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
